// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one uart_tx among NUM_REQ byte streams.
// Optional: define UART_TX_ARB_SRC_TAG_EN to prefix each granted packet with a 0xA0|g source tag byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ           = 2,
  parameter int IDLE_TIMEOUT_CLKS = 65535
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [NUM_REQ-1:0]     i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
  input  logic [NUM_REQ-1:0]     i_Req_Last,
  output logic [NUM_REQ-1:0]     o_Req_Ready,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic                   o_Timeout,
  output logic                   o_Busy,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done
);

  localparam int                 IW      = $clog2(NUM_REQ);
  localparam logic [15:0]        TO_LIM  = 16'(IDLE_TIMEOUT_CLKS);
  localparam logic [NUM_REQ-1:0] GNT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TAG       = 3'd1,
    S_FETCH     = 3'd2,
    S_LAUNCH    = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_WAIT_CLR  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               tx_dv_q, tx_dv_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic               last_q, last_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [15:0]        stall_q, stall_d;

  logic               found_s, found_hi_s;
  logic [IW-1:0]      pick_hi_s, pick_any_s, pick_s;
  logic               valid_g_s, last_g_s;
  logic [7:0]         byte_g_s;
  logic [15:0]        stall_inc_s;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : idx + IW'(1);
  endfunction

  // Round-robin candidate search and mux of the granted requester's inputs
  always_comb begin
    found_s    = 1'b0;
    found_hi_s = 1'b0;
    pick_hi_s  = {IW{1'b0}};
    pick_any_s = {IW{1'b0}};
    valid_g_s  = 1'b0;
    last_g_s   = 1'b0;
    byte_g_s   = 8'h00;
    // Descending scan: the lowest matching index is written last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      found_s    = found_s | i_Req_Valid[k];
      found_hi_s = found_hi_s | (i_Req_Valid[k] & (IW'(k) >= ptr_q));
      pick_any_s = i_Req_Valid[k] ? IW'(k) : pick_any_s;
      pick_hi_s  = (i_Req_Valid[k] && (IW'(k) >= ptr_q)) ? IW'(k) : pick_hi_s;
      valid_g_s  = (gidx_q == IW'(k)) ? i_Req_Valid[k] : valid_g_s;
      last_g_s   = (gidx_q == IW'(k)) ? i_Req_Last[k] : last_g_s;
      byte_g_s   = (gidx_q == IW'(k)) ? i_Req_Byte[8*k +: 8] : byte_g_s;
    end
    pick_s      = found_hi_s ? pick_hi_s : pick_any_s;
    stall_inc_s = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
  end

  // Next-state and next-output computation
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ready_d   = ready_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    stall_d   = stall_q;
    case (state_q)
      S_IDLE: begin
        // uart_tx has no reset, so a byte from before our reset may still be draining.
        if (!i_Tx_Active && !i_Tx_Done && found_s) begin
          gidx_d  = pick_s;
          grant_d = GNT_ONE << pick_s;
          stall_d = 16'd0;
`ifdef UART_TX_ARB_SRC_TAG_EN
          ready_d = {NUM_REQ{1'b0}};
          state_d = S_TAG;
`else
          ready_d = GNT_ONE << pick_s;
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef UART_TX_ARB_SRC_TAG_EN
      S_TAG: begin
        tx_byte_d = 8'hA0 | {{(8-IW){1'b0}}, gidx_q};
        last_d    = 1'b0;
        tx_dv_d   = 1'b1;
        state_d   = S_LAUNCH;
      end
`endif
      S_FETCH: begin
        if (valid_g_s && (ready_q != {NUM_REQ{1'b0}})) begin
          tx_byte_d = byte_g_s;
          last_d    = last_g_s;
          ready_d   = {NUM_REQ{1'b0}};
          tx_dv_d   = 1'b1;
          state_d   = S_LAUNCH;
        end else if ((TO_LIM != 16'd0) && (stall_inc_s >= TO_LIM)) begin
          stall_d   = stall_inc_s;
          timeout_d = 1'b1;
          grant_d   = {NUM_REQ{1'b0}};
          ready_d   = {NUM_REQ{1'b0}};
          ptr_d     = next_idx(gidx_q);
          state_d   = S_IDLE;
        end else begin
          stall_d = stall_inc_s;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done) begin
          state_d = S_WAIT_CLR;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_CLR: begin
        if (i_Tx_Done) begin
          state_d = S_WAIT_CLR;
        end else if (last_q) begin
          grant_d = {NUM_REQ{1'b0}};
          ptr_d   = next_idx(gidx_q);
          state_d = S_IDLE;
        end else begin
          ready_d = grant_q;
          stall_d = 16'd0;
          state_d = S_FETCH;
        end
      end
      default: begin
        grant_d = {NUM_REQ{1'b0}};
        ready_d = {NUM_REQ{1'b0}};
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      grant_q   <= {NUM_REQ{1'b0}};
      ready_q   <= {NUM_REQ{1'b0}};
      gidx_q    <= {IW{1'b0}};
      ptr_q     <= {IW{1'b0}};
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      stall_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      stall_q   <= stall_d;
    end
  end

  assign o_Req_Ready = ready_q;
  assign o_Grant     = grant_q;
  assign o_Timeout   = timeout_q;
  assign o_Busy      = busy_q;
  assign o_Tx_DV     = tx_dv_q;
  assign o_Tx_Byte   = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: behavioural uart_tx (4 clocks/bit), serial line decoder,
// per-requester byte FIFOs; expected {grant, byte} pairs are queued as stimulus is issued.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 20;
`ifdef UART_TX_ARB_SRC_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic            clk_s = 1'b0;
  logic            rst_s;
  logic [NR-1:0]   req_valid_s, req_last_s, req_ready_s, grant_s, hs_s;
  logic [8*NR-1:0] req_byte_s;
  logic            timeout_s, busy_s, tx_dv_s;
  logic [7:0]      tx_byte_s;
  logic            tx_active_s, tx_done_s, tx_serial_s;

  int tests_run    = 0;
  int tests_failed = 0;
  int to_cnt       = 0;
  int to_total     = 0;
  logic        prev_dv_r = 1'b0;
  logic [15:0] exp_q[$];
  logic [8:0]  rq_mem [NR][64];
  int          rq_head [NR];
  int          rq_tail [NR];

  // Free-running clock, 10 time units per cycle
  always #5 clk_s = ~clk_s;

  uart_tx_arbiter #(.NUM_REQ(NR), .IDLE_TIMEOUT_CLKS(TO)) dut (
    .i_Clock     (clk_s),
    .i_Reset     (rst_s),
    .i_Req_Valid (req_valid_s),
    .i_Req_Byte  (req_byte_s),
    .i_Req_Last  (req_last_s),
    .o_Req_Ready (req_ready_s),
    .o_Grant     (grant_s),
    .o_Timeout   (timeout_s),
    .o_Busy      (busy_s),
    .o_Tx_DV     (tx_dv_s),
    .o_Tx_Byte   (tx_byte_s),
    .i_Tx_Active (tx_active_s),
    .i_Tx_Done   (tx_done_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int r, input logic [7:0] b, input logic last);
    rq_mem[r][rq_tail[r] % 64] = {last, b};
    rq_tail[r]++;
  endtask

  task automatic exp_byte(input int r, input logic [7:0] b);
    exp_q.push_back({8'(1 << r), b});
  endtask

  task automatic exp_grant(input int r);
    if (TAG_EN) exp_byte(r, 8'hA0 | 8'(r));
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int k = 0; k < NR; k++) p = p | (rq_head[k] != rq_tail[k]);
    return p;
  endfunction

  // Requesters: present the FIFO head, pop on a valid&ready handshake
  initial begin
    req_valid_s = '0;
    req_last_s  = '0;
    req_byte_s  = '0;
    for (int k = 0; k < NR; k++) begin
      rq_head[k] = 0;
      rq_tail[k] = 0;
    end
    forever begin
      @(posedge clk_s);
      hs_s = req_valid_s & req_ready_s;
      #1;
      for (int k = 0; k < NR; k++) begin
        if (hs_s[k] && (rq_head[k] != rq_tail[k])) rq_head[k]++;
        if (rq_head[k] != rq_tail[k]) begin
          req_valid_s[k] = 1'b1;
          {req_last_s[k], req_byte_s[8*k +: 8]} = rq_mem[k][rq_head[k] % 64];
        end else begin
          req_valid_s[k] = 1'b0;
        end
      end
    end
  end

  // Behavioural uart_tx, 4 clocks per bit, done held 2 clocks, never reset
  initial begin
    logic [7:0] sh;
    tx_serial_s = 1'b1;
    tx_active_s = 1'b0;
    tx_done_s   = 1'b0;
    forever begin
      @(posedge clk_s);
      if (tx_dv_s) begin
        sh = tx_byte_s;
        #1 tx_active_s = 1'b1;
        tx_serial_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(posedge clk_s);
          #1 tx_serial_s = sh[i];
        end
        repeat (4) @(posedge clk_s);
        #1 tx_serial_s = 1'b1;
        repeat (4) @(posedge clk_s);
        #1 tx_active_s = 1'b0;
        tx_done_s = 1'b1;
        repeat (2) @(posedge clk_s);
        #1 tx_done_s = 1'b0;
      end
    end
  end

  // Line decoder: sample mid-bit, compare {owner, byte} with the scoreboard
  initial begin
    logic [7:0]  d;
    logic [NR-1:0] g;
    logic [15:0] e;
    forever begin
      @(negedge clk_s);
      if (tx_serial_s == 1'b0) begin
        g = grant_s;
        repeat (5) @(negedge clk_s);
        d[0] = tx_serial_s;
        for (int i = 1; i < 8; i++) begin
          repeat (4) @(negedge clk_s);
          d[i] = tx_serial_s;
        end
        repeat (4) @(negedge clk_s);
        check_eq("stop_bit", {31'd0, tx_serial_s}, 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hFFFF;
        check_eq("line_byte", {16'd0, 8'(g), d}, {16'd0, e});
      end
    end
  end

  // DV must be a single cycle and only while uart_tx is idle; count timeout pulses
  initial begin
    forever begin
      @(negedge clk_s);
      if (tx_dv_s) begin
        check_eq("dv_line_idle", {30'd0, tx_active_s, tx_done_s}, 32'd0);
        check_eq("dv_one_cycle", {31'd0, prev_dv_r}, 32'd0);
      end
      prev_dv_r = tx_dv_s;
      if (timeout_s) begin
        to_cnt++;
        to_total++;
        check_eq("timeout_grant_clr", {28'd0, grant_s}, 32'd0);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk_s);
    rst_s = 1'b1;
    for (int k = 0; k < NR; k++) rq_head[k] = rq_tail[k];
    @(negedge clk_s);
    check_eq("rst_ready",   {28'd0, req_ready_s}, 32'd0);
    check_eq("rst_grant",   {28'd0, grant_s}, 32'd0);
    check_eq("rst_timeout", {31'd0, timeout_s}, 32'd0);
    check_eq("rst_busy",    {31'd0, busy_s}, 32'd0);
    check_eq("rst_dv",      {31'd0, tx_dv_s}, 32'd0);
    check_eq("rst_byte",    {24'd0, tx_byte_s}, 32'd0);
    rst_s = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n = 0;
    while ((n < max) && ((exp_q.size() != 0) || busy_s || tx_active_s || tx_done_s || pending())) begin
      @(negedge clk_s);
      n++;
    end
    check_eq(tag, {31'd0, (n < max)}, 32'd1);
  endtask

  // Test sequence
  initial begin
    int n;
    rst_s = 1'b1;
    repeat (2) @(negedge clk_s);

    // Single requester with latency checks
    do_reset();
    send(0, 8'h55, 1'b0);
    send(0, 8'h3C, 1'b1);
    exp_grant(0);
    exp_byte(0, 8'h55);
    exp_byte(0, 8'h3C);
    @(negedge clk_s);
    @(negedge clk_s);
    check_eq("lat_grant", {28'd0, grant_s}, 32'd1);
    check_eq("lat_ready", {28'd0, req_ready_s}, TAG_EN ? 32'd0 : 32'd1);
    @(negedge clk_s);
    check_eq("lat_dv",   {31'd0, tx_dv_s}, 32'd1);
    check_eq("lat_byte", {24'd0, tx_byte_s}, TAG_EN ? 32'hA0 : 32'h55);
    wait_drain("drain_single", 1000);
    check_eq("single_grant_rel", {28'd0, grant_s}, 32'd0);
    check_eq("single_busy_rel",  {31'd0, busy_s}, 32'd0);

    // Round robin, both 2-byte packets pending from reset
    do_reset();
    send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b1);
    send(1, 8'h11, 1'b0); send(1, 8'h12, 1'b1);
    exp_grant(0); exp_byte(0, 8'h01); exp_byte(0, 8'h02);
    exp_grant(1); exp_byte(1, 8'h11); exp_byte(1, 8'h12);
    wait_drain("drain_rr1", 2000);

    // Round robin with req0 refilled immediately
    do_reset();
    send(0, 8'h21, 1'b0); send(0, 8'h22, 1'b1);
    send(0, 8'h23, 1'b0); send(0, 8'h24, 1'b1);
    send(1, 8'h31, 1'b0); send(1, 8'h32, 1'b1);
    exp_grant(0); exp_byte(0, 8'h21); exp_byte(0, 8'h22);
    exp_grant(1); exp_byte(1, 8'h31); exp_byte(1, 8'h32);
    exp_grant(0); exp_byte(0, 8'h23); exp_byte(0, 8'h24);
    wait_drain("drain_rr2", 3000);

    // Single-byte packets from all requesters rotate 0,1,2,3,0,1,2,3
    do_reset();
    for (int k = 0; k < NR; k++) begin
      send(k, 8'h40 + 8'(k), 1'b1);
      send(k, 8'h50 + 8'(k), 1'b1);
    end
    for (int k = 0; k < NR; k++) begin
      exp_grant(k); exp_byte(k, 8'h40 + 8'(k));
    end
    for (int k = 0; k < NR; k++) begin
      exp_grant(k); exp_byte(k, 8'h50 + 8'(k));
    end
    wait_drain("drain_rot", 4000);

    // Timeout: req1 stalls mid-packet, req0 pending takes over
    do_reset();
    to_cnt = 0;
    send(1, 8'h11, 1'b0);
    exp_grant(1); exp_byte(1, 8'h11);
    n = 0;
    while ((n < 50) && (grant_s != 4'b0010)) begin
      @(negedge clk_s);
      n++;
    end
    check_eq("to_req1_granted", {28'd0, grant_s}, 32'd2);
    send(0, 8'h41, 1'b0); send(0, 8'h42, 1'b1);
    exp_grant(0); exp_byte(0, 8'h41); exp_byte(0, 8'h42);
    wait_drain("drain_timeout", 2000);
    check_eq("timeout_pulses", to_cnt, 32'd1);

    // Single-byte packet from req2 (tag 0xA2 first when enabled)
    do_reset();
    send(2, 8'h7E, 1'b1);
    exp_grant(2); exp_byte(2, 8'h7E);
    wait_drain("drain_req2", 1000);

    // Reset in the middle of a data bit
    do_reset();
    send(2, 8'h5A, 1'b0);
    send(2, 8'hC3, 1'b1);
    exp_byte(2, TAG_EN ? 8'hA2 : 8'h5A);
    n = 0;
    while ((n < 50) && !tx_active_s) begin
      @(negedge clk_s);
      n++;
    end
    check_eq("rstmid_line_busy", {31'd0, tx_active_s}, 32'd1);
    repeat (10) @(negedge clk_s);
    do_reset();
    wait_drain("drain_rstmid", 1000);
    send(3, 8'h96, 1'b1);
    exp_grant(3); exp_byte(3, 8'h96);
    wait_drain("drain_after_rst", 1000);

    check_eq("timeout_total", to_total, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares one uart_tx transmitter among NUM_REQ byte-stream requesters, e.g. the flash-status reporter, the command echo path and the error logger.
- Accepts bytes through valid/ready handshakes, launches them one at a time into uart_tx via DV pulses, and holds the grant until the requester's last byte has fully left the line.
- Sits between the command/response logic and the uart_tx instance.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- IDLE_TIMEOUT_CLKS, 65535, max clocks the granted requester may stall mid-packet before its grant is revoked; 0 disables the timeout; counter is 16 bits.

Ports:
- i_Clock  input  1  system clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_Req_Valid  input  NUM_REQ  per-requester byte valid.
- i_Req_Byte  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- i_Req_Last  input  NUM_REQ  marks the final byte of a packet; qualified by valid.
- o_Req_Ready  output  NUM_REQ  per-requester ready.
- o_Grant  output  NUM_REQ  one-hot current owner; all zero when no requester owns the transmitter.
- o_Timeout  output  1  one-cycle pulse when a grant is revoked by the timeout.
- o_Busy  output  1  high in any state other than S_IDLE.
- o_Tx_DV  output  1  to uart_tx i_Tx_DV.
- o_Tx_Byte  output  8  to uart_tx i_Tx_Byte.
- i_Tx_Active  input  1  from uart_tx o_Tx_Active.
- i_Tx_Done  input  1  from uart_tx o_Tx_Done; stays high 2 clocks per byte.

Behaviour:
- Reset values: o_Req_Ready=0, o_Grant=0, o_Timeout=0, o_Busy=0, o_Tx_DV=0, o_Tx_Byte=0x00, round-robin pointer=0, state=S_IDLE.
- uart_tx has no reset, so the arbiter may be reset while a byte is still on the line.
- States:
  - S_IDLE: if i_Tx_Active=0, i_Tx_Done=0 and any valid is high, grant the first valid requester at or after the pointer (circular) -> S_FETCH. Otherwise stay.
  - S_FETCH: o_Req_Ready[g]=1 for the granted g only.
    - On valid&&ready: capture the byte into o_Tx_Byte, capture last into an internal flag -> S_LAUNCH.
    - Each cycle without valid increments the stall counter. When the counter reaches IDLE_TIMEOUT_CLKS (nonzero): pulse o_Timeout, clear o_Grant, pointer=g+1 mod NUM_REQ -> S_IDLE.
  - S_LAUNCH: o_Tx_DV=1 for exactly one cycle -> S_WAIT_DONE.
  - S_WAIT_DONE: wait for i_Tx_Done=1 -> S_WAIT_CLR.
  - S_WAIT_CLR: wait for i_Tx_Done=0, which means uart_tx is back in idle.
    - If the last flag is clear: -> S_FETCH (grant kept, stall counter cleared).
    - If set: clear o_Grant, pointer=g+1 mod NUM_REQ -> S_IDLE.
- Latency: valid seen in S_IDLE at cycle N -> o_Grant and o_Req_Ready high at N+1. If valid is still high at N+1 the byte is taken then, and o_Tx_DV is high at N+2.
- o_Tx_Byte is held stable from capture until the next capture.
- No interleaving: bytes of different packets never mix on the line. Non-granted requesters see ready=0 and may hold valid indefinitely.
- Valid dropping while granted but before the byte is taken is legal; it only counts toward the timeout.
- A requester with a single-byte packet (last=1 on its first byte) releases the grant after that byte.
- Pointer is not advanced in S_IDLE when nothing is granted.
- Stall counter saturates at 16 bits.
- Reset mid-byte: the arbiter returns to S_IDLE and re-arbitrates only after uart_tx drains (i_Tx_Active=0 and i_Tx_Done=0). The interrupted packet is abandoned; the requester sees no further ready.

Optional Feature:
- Macro UART_TX_ARB_SRC_TAG_EN.
- With it defined: on every grant, insert state S_TAG before the first S_FETCH. S_TAG drives o_Tx_Byte = 0xA0 | g and sends it through S_LAUNCH/S_WAIT_DONE/S_WAIT_CLR with the last flag forced 0, then continues to S_FETCH. The requester's first byte is accepted only after the tag byte completes. The timeout does not count during the tag.
- Without it defined: no tag byte is sent; the behaviour is exactly as above.

Test Plan:
- Setup: uart_tx with CLKS_PER_BIT=4; line monitor decodes the serial output.
- Single requester: req0 sends 0x55, 0x3C(last) -> line carries 0x55 then 0x3C; o_Grant=01 throughout; grant released after the second byte's done falls; o_Busy returns to 0.
- Round robin: req0 and req1 both hold 2-byte packets from reset -> order is req0 packet then req1 packet. Repeated with req0 refilled immediately -> req1 is granted before req0's second packet.
- Single-byte packets from all NUM_REQ=4 requesters held continuously -> grants rotate 0,1,2,3,0, one byte each; no byte is lost or duplicated.
- Timeout: IDLE_TIMEOUT_CLKS=20; req1 sends 0x11 with no last, then drops valid -> o_Timeout pulses once; grant cleared; pending req0 is granted next; line shows only 0x11 from req1.
- Reset mid-byte: assert i_Reset during a data bit -> all outputs go to reset values next cycle; no o_Tx_DV until uart_tx's done has fallen; a new packet then transmits correctly.
- With UART_TX_ARB_SRC_TAG_EN: req2 sends 0x7E(last) -> line carries 0xA2 then 0x7E.
